// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, FSM states,
// accumulator source codes and small opcode classification helpers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ALU0 = 4'h4;
  localparam logic [3:0] OP_ALU1 = 4'h5;
  localparam logic [3:0] OP_ALU2 = 4'h6;
  localparam logic [3:0] OP_ALU3 = 4'h7;
  localparam logic [3:0] OP_LDN  = 4'h8;
  localparam logic [3:0] OP_STN  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JMA  = 4'hC;
  localparam logic [3:0] OP_RSVD0 = 4'hD;
  localparam logic [3:0] OP_RSVD1 = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Mux_Acc_In_Sel codes
  localparam logic [1:0] ACC_SRC_TGT = 2'd1;
  localparam logic [1:0] ACC_SRC_BUS = 2'd2;
  localparam logic [1:0] ACC_SRC_ALU = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_IND    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcodes whose EXEC phase needs a memory transfer
  function automatic logic exec_uses_mem(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op[3:2] == 2'b01) ||
           (op == OP_LDN) || (op == OP_STN) || (op == OP_JMA);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == OP_RSVD0) || (op == OP_RSVD1);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts consecutive stalled cycles of a memory request and flags a timeout
// in the cycle where the stall count would reach TIMEOUT_CYCLES.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] count_reg;

      // Stall counter: restarts whenever the request completes or goes away
      always_ff @(posedge clk) begin
        if (srst || clear) begin
          count_reg <= '0;
        end else if (enable) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      // The Nth stalled cycle is the one that trips the watchdog
      assign timeout = enable && (count_reg == LAST);
    end else begin : g_off
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/controller_fsm.sv
// Control unit of the accumulator CPU: fetch/decode/execute sequencing,
// memory handshake with bus watchdog, and halt handling.
module controller_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] IReg_Data_Out,
  input  logic [7:0] Acc_Data_Out,
  input  logic       Mem_Ready,
  output logic       Mem_Rd,
  output logic       Mem_Wr,
  output logic       IReg_En,
  output logic       PC_En,
  output logic       IAR_En,
  output logic       Acc_En,
  output logic       Mux_PC_Add_Sel,
  output logic       Mux_PC_In_Sel,
  output logic       IReg_Buffer_Sel,
  output logic       PC_Buffer_Sel,
  output logic       IAR_Buffer_Sel,
  output logic       Acc_Buffer_Sel,
  output logic [1:0] Mux_Acc_In_Sel,
  output logic [1:0] ALU_Sel,
  output logic       Halted,
  output logic       Bus_Err,
  output logic       Illegal,
  output logic       Instr_Done
);

  state_t     state_reg, state_next;
  logic       start_reg;
  logic       bus_err_reg, bus_err_next;
  logic       illegal_reg, illegal_next;
  logic       block;
  logic       pending;
  logic       wd_en;
  logic       wd_timeout;
  logic       done;
  logic [3:0] opcode;

  assign opcode = IReg_Data_Out[7:4];
  // Outputs are silenced during reset and the single settling cycle after it
  assign block  = rst | start_reg;

  // A request is outstanding in every memory-accessing state
  assign pending = (state_reg == ST_FETCH) || (state_reg == ST_IND) ||
                   ((state_reg == ST_EXEC) && exec_uses_mem(opcode));
  assign wd_en   = pending && !Mem_Ready && !block;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .srst   (rst),
    .clear  (!wd_en),
    .enable (wd_en),
    .timeout(wd_timeout)
  );

  // State and sticky status registers; the FSM holds in FETCH for the settling cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      start_reg   <= 1'b1;
      bus_err_reg <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      if (!start_reg) begin
        state_reg <= state_next;
      end
      bus_err_reg <= bus_err_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_next      = state_reg;
    bus_err_next    = bus_err_reg;
    illegal_next    = illegal_reg;
    done            = 1'b0;
    Mem_Rd          = 1'b0;
    Mem_Wr          = 1'b0;
    IReg_En         = 1'b0;
    PC_En           = 1'b0;
    IAR_En          = 1'b0;
    Acc_En          = 1'b0;
    Mux_PC_Add_Sel  = 1'b0;
    Mux_PC_In_Sel   = 1'b0;
    IReg_Buffer_Sel = 1'b0;
    PC_Buffer_Sel   = 1'b0;
    IAR_Buffer_Sel  = 1'b0;
    Acc_Buffer_Sel  = 1'b0;
    Mux_Acc_In_Sel  = 2'd0;
    ALU_Sel         = 2'd0;

    case (state_reg)
      ST_FETCH: begin
        PC_Buffer_Sel = 1'b1;
        Mem_Rd        = 1'b1;
        if (Mem_Ready) begin
          IReg_En        = 1'b1;
          PC_En          = 1'b1;
          Mux_PC_Add_Sel = 1'b1;
          state_next     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HLT) begin
          state_next = ST_HALT;
        end else if ((opcode == OP_LDN) || (opcode == OP_STN)) begin
          state_next = ST_IND;
        end else if (HALT_ON_ILLEGAL && is_reserved(opcode)) begin
          state_next   = ST_HALT;
          illegal_next = 1'b1;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_IND: begin
        IReg_Buffer_Sel = 1'b1;
        Mem_Rd          = 1'b1;
        if (Mem_Ready) begin
          IAR_En     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_LDI: begin
            Acc_En         = 1'b1;
            Mux_Acc_In_Sel = ACC_SRC_TGT;
            done           = 1'b1;
          end
          OP_LDA: begin
            IReg_Buffer_Sel = 1'b1;
            Mem_Rd          = 1'b1;
            Mux_Acc_In_Sel  = ACC_SRC_BUS;
            Acc_En          = Mem_Ready;
            done            = Mem_Ready;
          end
          OP_STA: begin
            IReg_Buffer_Sel = 1'b1;
            Mem_Wr          = 1'b1;
            Acc_Buffer_Sel  = 1'b1;
            done            = Mem_Ready;
          end
          OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3: begin
            IReg_Buffer_Sel = 1'b1;
            Mem_Rd          = 1'b1;
            Mux_Acc_In_Sel  = ACC_SRC_ALU;
            ALU_Sel         = opcode[1:0];
            Acc_En          = Mem_Ready;
            done            = Mem_Ready;
          end
          OP_LDN: begin
            IAR_Buffer_Sel = 1'b1;
            Mem_Rd         = 1'b1;
            Mux_Acc_In_Sel = ACC_SRC_BUS;
            Acc_En         = Mem_Ready;
            done           = Mem_Ready;
          end
          OP_STN: begin
            IAR_Buffer_Sel = 1'b1;
            Mem_Wr         = 1'b1;
            Acc_Buffer_Sel = 1'b1;
            done           = Mem_Ready;
          end
          OP_JMP: begin
            PC_En = 1'b1;
            done  = 1'b1;
          end
          OP_JZ: begin
            PC_En = (Acc_Data_Out == 8'd0);
            done  = 1'b1;
          end
          OP_JMA: begin
            IReg_Buffer_Sel = 1'b1;
            Mem_Rd          = 1'b1;
            Mux_PC_In_Sel   = 1'b1;
            PC_En           = Mem_Ready;
            done            = Mem_Ready;
          end
          default: done = 1'b1;  // NOP and reserved opcodes when not halting
        endcase
        if (done) begin
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_HALT;  // HALT: only reset leaves
    endcase

    // A watchdog expiry cancels the transfer outright: no loads, no retire
    if (wd_timeout) begin
      state_next   = ST_HALT;
      bus_err_next = 1'b1;
    end
    if (wd_timeout || block) begin
      done            = 1'b0;
      Mem_Rd          = 1'b0;
      Mem_Wr          = 1'b0;
      IReg_En         = 1'b0;
      PC_En           = 1'b0;
      IAR_En          = 1'b0;
      Acc_En          = 1'b0;
      Mux_PC_Add_Sel  = 1'b0;
      Mux_PC_In_Sel   = 1'b0;
      IReg_Buffer_Sel = 1'b0;
      PC_Buffer_Sel   = 1'b0;
      IAR_Buffer_Sel  = 1'b0;
      Acc_Buffer_Sel  = 1'b0;
      Mux_Acc_In_Sel  = 2'd0;
      ALU_Sel         = 2'd0;
    end

    Instr_Done = done;
    Halted     = ((state_reg == ST_HALT) || wd_timeout) && !block;
    Bus_Err    = (bus_err_reg || wd_timeout) && !block;
    Illegal    = illegal_reg && !block;
  end

endmodule
